// File: rtl/acc_window_unit.sv
// Windowed accumulator: sums a selected operand over WINDOW accepted samples,
// then publishes the total with a one-cycle strobe and a sticky overflow flag.
module acc_window_unit #(
    parameter int unsigned NB_DATA   = 3,
    parameter int unsigned NB_ACC    = 6,
    parameter int unsigned NB_SELECT = 2,
    parameter int unsigned WINDOW    = 4,
    parameter int unsigned NB_CNT    = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [NB_DATA-1:0]   i_data1,
    input  logic [NB_DATA-1:0]   i_data2,
    input  logic [NB_SELECT-1:0] i_sel,
    input  logic                 i_sat,
    input  logic                 i_clear,
    output logic [NB_ACC-1:0]    o_acc,
    output logic [NB_CNT-1:0]    o_count,
    output logic [NB_ACC-1:0]    o_data,
    output logic                 o_valid,
    output logic                 o_overflow
);

    localparam logic [NB_SELECT-1:0] SelData1 = NB_SELECT'(0);
    localparam logic [NB_SELECT-1:0] SelData2 = NB_SELECT'(1);
    localparam logic [NB_SELECT-1:0] SelPair  = NB_SELECT'(2);
    localparam logic [NB_SELECT-1:0] SelSub   = NB_SELECT'(3);
    localparam logic [NB_CNT-1:0]    LastCnt  = NB_CNT'(WINDOW - 1);

    logic [NB_ACC-1:0] acc_q, acc_d;
    logic [NB_CNT-1:0] cnt_q, cnt_d;
    logic              sticky_q, sticky_d;
    logic [NB_ACC-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;

    logic [NB_DATA:0]  pair;
    logic [NB_ACC:0]   acc_ext;
    logic [NB_ACC:0]   ext1;
    logic [NB_ACC:0]   add_op;
    logic [NB_ACC:0]   sum;
    logic [NB_ACC:0]   diff;
    logic [NB_ACC:0]   raw;
    logic              is_sub;
    logic              samp_ovf;
    logic [NB_ACC-1:0] next_val;
    logic              last;

    // Operand selection and one-sample arithmetic at NB_ACC+1 bits.
    always_comb begin
        pair    = {1'b0, i_data1} + {1'b0, i_data2};
        acc_ext = {1'b0, acc_q};
        ext1    = {{(NB_ACC + 1 - NB_DATA){1'b0}}, i_data1};
        is_sub  = 1'b0;
        add_op  = '0;
        case (i_sel)
            SelData1: add_op = ext1;
            SelData2: add_op = {{(NB_ACC + 1 - NB_DATA){1'b0}}, i_data2};
            SelPair:  add_op = {{(NB_ACC - NB_DATA){1'b0}}, pair};
            SelSub:   is_sub = 1'b1;
            default:  add_op = '0;
        endcase
        sum  = acc_ext + add_op;
        diff = acc_ext - ext1;
        raw  = is_sub ? diff : sum;
        // Carry-out flags an add overflow; a borrow flags a subtract underflow.
        samp_ovf = is_sub ? (ext1 > acc_ext) : raw[NB_ACC];
        if (samp_ovf && i_sat) begin
            next_val = is_sub ? '0 : '1;
        end else begin
            next_val = raw[NB_ACC-1:0];
        end
    end

    // Window bookkeeping: clear beats a sample; the closing sample publishes.
    always_comb begin
        last     = (cnt_q == LastCnt);
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        data_d   = data_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        if (i_clear) begin
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (i_valid) begin
            if (last) begin
                data_d   = next_val;
                ovf_d    = sticky_q | samp_ovf;
                valid_d  = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
                sticky_d = 1'b0;
            end else begin
                acc_d    = next_val;
                cnt_d    = cnt_q + NB_CNT'(1);
                sticky_d = sticky_q | samp_ovf;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_acc      = acc_q;
    assign o_count    = cnt_q;
    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_acc_window_unit.sv
// Directed bench for acc_window_unit: WINDOW=4 (default), 8 and 1 instances
// share one stimulus set; expected values are hand-computed constants.
module tb_acc_window_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [2:0] d1;
    logic [2:0] d2;
    logic [1:0] sel;
    logic       sat;
    logic       clr;

    logic [5:0] acc4, data4;
    logic [1:0] cnt4;
    logic       vld4, ovf4;
    logic [5:0] acc8, data8;
    logic [2:0] cnt8;
    logic       vld8, ovf8;
    logic [5:0] acc1, data1;
    logic [0:0] cnt1;
    logic       vld1, ovf1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    acc_window_unit dut4 (
        .clk(clk), .i_rst(rst), .i_valid(valid), .i_data1(d1), .i_data2(d2),
        .i_sel(sel), .i_sat(sat), .i_clear(clr), .o_acc(acc4), .o_count(cnt4),
        .o_data(data4), .o_valid(vld4), .o_overflow(ovf4)
    );

    acc_window_unit #(.WINDOW(8)) dut8 (
        .clk(clk), .i_rst(rst), .i_valid(valid), .i_data1(d1), .i_data2(d2),
        .i_sel(sel), .i_sat(sat), .i_clear(clr), .o_acc(acc8), .o_count(cnt8),
        .o_data(data8), .o_valid(vld8), .o_overflow(ovf8)
    );

    acc_window_unit #(.WINDOW(1)) dut1 (
        .clk(clk), .i_rst(rst), .i_valid(valid), .i_data1(d1), .i_data2(d2),
        .i_sel(sel), .i_sat(sat), .i_clear(clr), .o_acc(acc1), .o_count(cnt1),
        .o_data(data1), .o_valid(vld1), .o_overflow(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0; clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk4_all_zero(input string tag);
        chk({tag, "_acc"}, 32'(acc4), 0);
        chk({tag, "_cnt"}, 32'(cnt4), 0);
        chk({tag, "_data"}, 32'(data4), 0);
        chk({tag, "_vld"}, 32'(vld4), 0);
        chk({tag, "_ovf"}, 32'(ovf4), 0);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; d1 = '0; d2 = '0; sel = '0; sat = 1'b0; clr = 1'b0;

        // 1. Reset with random inputs, then idle after release.
        for (int i = 0; i < 2; i++) begin
            valid = 1'($urandom); d1 = 3'($urandom); d2 = 3'($urandom);
            sel = 2'($urandom); sat = 1'($urandom); clr = 1'($urandom);
            tick();
            chk4_all_zero("rst");
        end
        rst = 1'b0; valid = 1'b0; clr = 1'b0; sat = 1'b0;
        tick();
        chk4_all_zero("idle");

        // 2. sel=10, 7+7 over one window of 4.
        sel = 2'b10; d1 = 3'd7; d2 = 3'd7; valid = 1'b1;
        tick(); chk("w4_acc1", 32'(acc4), 14); chk("w4_cnt1", 32'(cnt4), 1);
        tick(); chk("w4_acc2", 32'(acc4), 28);
        tick(); chk("w4_acc3", 32'(acc4), 42); chk("w4_vld3", 32'(vld4), 0);
        tick();
        chk("w4_vld", 32'(vld4), 1); chk("w4_data", 32'(data4), 56);
        chk("w4_ovf", 32'(ovf4), 0); chk("w4_acc0", 32'(acc4), 0);
        chk("w4_cnt0", 32'(cnt4), 0);
        valid = 1'b0;
        tick(); chk("w4_pulse", 32'(vld4), 0); chk("w4_hold", 32'(data4), 56);

        // 3. WINDOW=8, 8 x 14: wrap gives 112 mod 64, saturate pins at 63.
        do_reset();
        sel = 2'b10; d1 = 3'd7; d2 = 3'd7; sat = 1'b0; valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("w8_acc5", 32'(acc8), 6); chk("w8_cnt5", 32'(cnt8), 5);
        for (int i = 0; i < 3; i++) tick();
        chk("w8_vld", 32'(vld8), 1); chk("w8_wrap", 32'(data8), 48);
        chk("w8_wovf", 32'(ovf8), 1);
        do_reset();
        sat = 1'b1; valid = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("w8_sat", 32'(data8), 63); chk("w8_sovf", 32'(ovf8), 1);

        // 4. Subtract underflow then adds, wrap and saturate.
        do_reset();
        sat = 1'b0; valid = 1'b1; sel = 2'b11; d1 = 3'd3;
        tick(); chk("sub_wrap", 32'(acc4), 61);
        sel = 2'b00; d1 = 3'd1;
        for (int i = 0; i < 3; i++) tick();
        chk("sub_w_vld", 32'(vld4), 1); chk("sub_w_data", 32'(data4), 0);
        chk("sub_w_ovf", 32'(ovf4), 1);
        do_reset();
        sat = 1'b1; valid = 1'b1; sel = 2'b11; d1 = 3'd3;
        tick(); chk("sub_sat", 32'(acc4), 0);
        sel = 2'b00; d1 = 3'd1;
        for (int i = 0; i < 3; i++) tick();
        chk("sub_s_data", 32'(data4), 3); chk("sub_s_ovf", 32'(ovf4), 1);

        // 5. Clear drops the coincident sample and restarts the window.
        do_reset();
        sat = 1'b0; sel = 2'b00; d1 = 3'd5; valid = 1'b1;
        tick(); tick();
        chk("clr_acc_pre", 32'(acc4), 10); chk("clr_cnt_pre", 32'(cnt4), 2);
        clr = 1'b1;
        tick();
        chk("clr_acc", 32'(acc4), 0); chk("clr_cnt", 32'(cnt4), 0);
        chk("clr_vld", 32'(vld4), 0);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("clr_vld_post", 32'(vld4), 1); chk("clr_data", 32'(data4), 20);

        // 6. Gapped valid: count advances only on accepted samples.
        do_reset();
        sel = 2'b01; d2 = 3'd2;
        begin
            logic [6:0] pat;
            int         exp_cnt [7];
            pat = 7'b1011001; // applied LSB first: 1,0,0,1,1,0,1
            exp_cnt = '{1, 1, 1, 2, 3, 3, 0};
            for (int i = 0; i < 7; i++) begin
                valid = pat[i];
                tick();
                chk("gap_cnt", 32'(cnt4), 32'(exp_cnt[i]));
                chk("gap_vld", 32'(vld4), (i == 6) ? 1 : 0);
            end
        end
        chk("gap_data", 32'(data4), 8);
        valid = 1'b0;
        tick(); tick();
        chk("gap_hold", 32'(data4), 8); chk("gap_idle_vld", 32'(vld4), 0);

        // Reset mid-window discards the partial sum and the held result.
        valid = 1'b1;
        tick(); chk("midrst_acc_pre", 32'(acc4), 2);
        do_reset();
        #0;
        chk("midrst_acc", 32'(acc4), 0); chk("midrst_data", 32'(data4), 0);

        // WINDOW=1: every sample closes a window starting from 0.
        sat = 1'b0; sel = 2'b10; d1 = 3'd3; d2 = 3'd2; valid = 1'b1;
        tick();
        chk("w1_vld", 32'(vld1), 1); chk("w1_data", 32'(data1), 5);
        chk("w1_cnt", 32'(cnt1), 0); chk("w1_acc", 32'(acc1), 0);
        sel = 2'b11;
        tick();
        chk("w1_sub", 32'(data1), 61); chk("w1_ovf", 32'(ovf1), 1);
        chk("w1_vld2", 32'(vld1), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
